// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - handshake and SPI pin bundle for spi_master_param
//
// Groups the controller handshake (start/data_wr/busy/done/data_rd), the SPI pins
// (spi_clk/cs/mosi/miso) and the debug taps (state/count) of one SPI master.
//   master modport : the SPI master itself (drives handshake status and SPI pins)
//   slave modport  : the local controller / board side (drives start, data_wr, miso)
interface spi_master_param_if #(
    parameter int DATA_W = 8
);
    logic                           start;
    logic [DATA_W-1:0]              data_wr;
    logic                           busy;
    logic                           done;
    logic [DATA_W-1:0]              data_rd;
    logic                           spi_clk;
    logic                           cs;
    logic                           mosi;
    logic                           miso;
    logic [1:0]                     state;
    logic [$clog2(DATA_W+1)-1:0]    count;

    modport master (
        input  start, data_wr, miso,
        output busy, done, data_rd, spi_clk, cs, mosi, state, count
    );

    modport slave (
        output start, data_wr, miso,
        input  busy, done, data_rd, spi_clk, cs, mosi, state, count
    );
endinterface

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master, single chip select
//
// Ports:
//   clk    in  system clock, all logic on posedge
//   reset  in  synchronous, active-high
//   bus    spi_master_param_if.master
//          start/data_wr in, busy/done/data_rd out  : controller handshake
//          spi_clk/cs/mosi out, miso in              : SPI pins (cs active-low)
//          state/count out                            : debug (FSM state, bits sampled)
// Parameters: DATA_W word width, CLK_DIV clk cycles per SCLK half-period,
//             CPOL/CPHA SPI mode, MSB_FIRST bit order.
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_master_param_if.master   bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TOG_W = $clog2(2 * DATA_W + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_W - 1);
    localparam logic             IDLE_CLK = (CPOL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [DIV_W-1:0]   div_cnt;
    logic [TOG_W-1:0]   tog_cnt;
    logic [DATA_W-1:0]  tx_reg;
    logic [DATA_W-1:0]  rx_reg;
    logic [CNT_W-1:0]   count_q;
    logic [DATA_W-1:0]  data_rd_q;
    logic               spi_clk_q;
    logic               cs_q;
    logic               mosi_q;
    logic               busy_q;
    logic               done_q;

    logic               div_last;
    logic               leading;
    logic               accept;
    logic               toggle;
    logic               sample_en;
    logic               shift_en;
    logic               finish;

    assign div_last = (div_cnt == DIV_LAST);
    // Toggles are numbered from 1; an even number of toggles done means the
    // next one is a leading (odd-numbered) edge.
    assign leading  = ~tog_cnt[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        toggle    = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (div_last) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (div_last) begin
                    toggle = 1'b1;
                    if (CPHA == 0) begin
                        // First bit is already on mosi, so the final trailing
                        // edge has nothing left to shift.
                        sample_en = leading;
                        shift_en  = ~leading && (tog_cnt != TOG_LAST);
                    end else begin
                        // First bit was presented on entry; the first leading
                        // edge would otherwise skip it.
                        sample_en = ~leading;
                        shift_en  = leading && (tog_cnt != '0);
                    end
                    if (tog_cnt == TOG_LAST) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (div_last) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            tog_cnt   <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            count_q   <= '0;
            data_rd_q <= '0;
            spi_clk_q <= IDLE_CLK;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (state_q != IDLE) begin
                div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
            end

            if (accept) begin
                tx_reg    <= bus.data_wr;
                rx_reg    <= '0;
                count_q   <= '0;
                div_cnt   <= '0;
                tog_cnt   <= '0;
                spi_clk_q <= IDLE_CLK;
                cs_q      <= 1'b0;
                busy_q    <= 1'b1;
                mosi_q    <= (MSB_FIRST != 0) ? bus.data_wr[DATA_W-1] : bus.data_wr[0];
            end

            if (toggle) begin
                spi_clk_q <= ~spi_clk_q;
                tog_cnt   <= tog_cnt + TOG_W'(1);
            end

            if (sample_en) begin
                count_q <= count_q + CNT_W'(1);
                if (MSB_FIRST != 0) begin
                    rx_reg <= {rx_reg[DATA_W-2:0], bus.miso};
                end else begin
                    rx_reg <= {bus.miso, rx_reg[DATA_W-1:1]};
                end
            end

            if (shift_en) begin
                if (MSB_FIRST != 0) begin
                    tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
                    mosi_q <= tx_reg[DATA_W-2];
                end else begin
                    tx_reg <= {1'b0, tx_reg[DATA_W-1:1]};
                    mosi_q <= tx_reg[1];
                end
            end

            if (finish) begin
                cs_q      <= 1'b1;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                mosi_q    <= 1'b0;
                data_rd_q <= rx_reg;
            end
        end
    end

    assign bus.state   = state_q;
    assign bus.count   = count_q;
    assign bus.data_rd = data_rd_q;
    assign bus.spi_clk = spi_clk_q;
    assign bus.cs      = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
